// File: rtl/execute_stage.sv
// RV32-style execute stage with a valid/ready handshake, a registered result slot and
// an iterative shift-add multiplier next to the single-cycle alu.

package execute_stage_pkg;
   localparam logic [5:0] ALU_ADD    = 6'd0;
   localparam logic [5:0] ALU_SUB    = 6'd1;
   localparam logic [5:0] ALU_SLL    = 6'd2;
   localparam logic [5:0] ALU_SLT    = 6'd3;
   localparam logic [5:0] ALU_SLTU   = 6'd4;
   localparam logic [5:0] ALU_XOR    = 6'd5;
   localparam logic [5:0] ALU_SRL    = 6'd6;
   localparam logic [5:0] ALU_SRA    = 6'd7;
   localparam logic [5:0] ALU_OR     = 6'd8;
   localparam logic [5:0] ALU_AND    = 6'd9;
   localparam logic [5:0] ALU_LUI    = 6'd10;
   localparam logic [5:0] ALU_JAL    = 6'd11;
   localparam logic [5:0] ALU_JALR   = 6'd12;
   localparam logic [5:0] ALU_BEQ    = 6'd13;
   localparam logic [5:0] ALU_BNE    = 6'd14;
   localparam logic [5:0] ALU_BLT    = 6'd15;
   localparam logic [5:0] ALU_BGE    = 6'd16;
   localparam logic [5:0] ALU_BLTU   = 6'd17;
   localparam logic [5:0] ALU_BGEU   = 6'd18;
   localparam logic [5:0] ALU_MUL    = 6'd19;
   localparam logic [5:0] ALU_MULH   = 6'd20;
   localparam logic [5:0] ALU_MULHSU = 6'd21;
   localparam logic [5:0] ALU_MULHU  = 6'd22;

   localparam logic [1:0] OP_TYPE_NONE = 2'd0;
   localparam logic [1:0] OP_TYPE_REG  = 2'd1;
   localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
   localparam logic [1:0] OP_TYPE_PC   = 2'd3;
endpackage

module execute_alu
   import execute_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [5:0]      alucode,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic [XLEN-1:0] result,
   output logic            br_taken
);
   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt_s;
   assign shamt_s = op2[SHW-1:0];

   // Jumps produce the link address op1+4, so op1 is expected to select the pc.
   always_comb begin
      result   = '0;
      br_taken = 1'b0;
      case (alucode)
         ALU_ADD:  result = op1 + op2;
         ALU_SUB:  result = op1 - op2;
         ALU_SLL:  result = op1 << shamt_s;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op1 < op2)};
         ALU_XOR:  result = op1 ^ op2;
         ALU_SRL:  result = op1 >> shamt_s;
         ALU_SRA:  result = $unsigned($signed(op1) >>> shamt_s);
         ALU_OR:   result = op1 | op2;
         ALU_AND:  result = op1 & op2;
         ALU_LUI:  result = op2;
         ALU_JAL, ALU_JALR: begin
            result   = op1 + XLEN'(32'd4);
            br_taken = 1'b1;
         end
         ALU_BEQ:  br_taken = (op1 == op2);
         ALU_BNE:  br_taken = (op1 != op2);
         ALU_BLT:  br_taken = ($signed(op1) < $signed(op2));
         ALU_BGE:  br_taken = ($signed(op1) >= $signed(op2));
         ALU_BLTU: br_taken = (op1 < op2);
         ALU_BGEU: br_taken = (op1 >= op2);
         default: begin
            result   = '0;
            br_taken = 1'b0;
         end
      endcase
   end
endmodule

module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc,
   input  logic [5:0]      alucode,
   input  logic [1:0]      aluop1_type,
   input  logic [1:0]      aluop2_type,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] imm,
   input  logic [4:0]      rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_alu_result,
   output logic [XLEN-1:0] out_pc_next,
   output logic            out_br_taken,
   output logic            out_misaligned,
   output logic [4:0]      out_rd
);
   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL_BUSY = 1'b1} state_t;

   state_t              state_q;
   logic [CW-1:0]       cnt_q;
   logic [2*XLEN-1:0]   mcand_q, acc_q;
   logic [XLEN-1:0]     mplier_q, mpc_q;
   logic                msign_q, mhigh_q;
   logic [4:0]          mrd_q;

   logic                out_valid_q, out_br_taken_q, out_misaligned_q;
   logic [XLEN-1:0]     out_alu_result_q, out_pc_next_q;
   logic [4:0]          out_rd_q;

   logic [XLEN-1:0]     op1_s, op2_s, alu_result_s, pc_next_d, a_mag_s, b_mag_s;
   logic                alu_taken_s, misaligned_d, is_mul_s, a_neg_s, b_neg_s;
   logic                slot_free_s, accept_s, mul_last_s;
   logic [2*XLEN-1:0]   acc_step_d, final_mag_d, prod_d;
   logic [XLEN-1:0]     mul_result_d;

   // Operand selection for the alu and multiplier.
   always_comb begin
      case (aluop1_type)
         OP_TYPE_REG: op1_s = rs1;
         OP_TYPE_IMM: op1_s = imm;
         OP_TYPE_PC:  op1_s = pc;
         default:     op1_s = '0;
      endcase
      case (aluop2_type)
         OP_TYPE_REG: op2_s = rs2;
         OP_TYPE_IMM: op2_s = imm;
         OP_TYPE_PC:  op2_s = pc;
         default:     op2_s = '0;
      endcase
   end

   execute_alu #(.XLEN(XLEN)) u_alu (
      .alucode  (alucode),
      .op1      (op1_s),
      .op2      (op2_s),
      .result   (alu_result_s),
      .br_taken (alu_taken_s)
   );

   assign is_mul_s    = (alucode == ALU_MUL) || (alucode == ALU_MULH) ||
                        (alucode == ALU_MULHSU) || (alucode == ALU_MULHU);
   assign slot_free_s = !out_valid_q || out_ready;
   assign in_ready    = (state_q == S_IDLE) && slot_free_s && !flush;
   assign accept_s    = in_valid && in_ready;

   // Next pc and alignment flag for single-cycle ops.
   always_comb begin
      if (alu_taken_s && (alucode == ALU_JALR)) begin
         pc_next_d = (rs1 + imm) & ~XLEN'(32'd1);
      end else if (alu_taken_s) begin
         pc_next_d = pc + imm;
      end else begin
         pc_next_d = pc + XLEN'(32'd4);
      end
      misaligned_d = ALIGN_CHECK && alu_taken_s && pc_next_d[1];
   end

   // Operand magnitudes; MUL/MULH treat both sides as signed, MULHSU only rs1.
   always_comb begin
      a_neg_s = (alucode != ALU_MULHU) && op1_s[XLEN-1];
      b_neg_s = ((alucode == ALU_MUL) || (alucode == ALU_MULH)) && op2_s[XLEN-1];
      a_mag_s = a_neg_s ? ('0 - op1_s) : op1_s;
      b_mag_s = b_neg_s ? ('0 - op2_s) : op2_s;
   end

   // Shift-add datapath; once cnt_q reaches XLEN, acc_q already holds the final magnitude.
   always_comb begin
      acc_step_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
      final_mag_d  = (cnt_q == CW'(XLEN)) ? acc_q : acc_step_d;
      prod_d       = msign_q ? ('0 - final_mag_d) : final_mag_d;
      mul_result_d = mhigh_q ? prod_d[2*XLEN-1:XLEN] : prod_d[XLEN-1:0];
      mul_last_s   = (cnt_q >= CW'(XLEN - 1));
   end

   // Control FSM, multiplier state and the output slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         mcand_q          <= '0;
         acc_q            <= '0;
         mplier_q         <= '0;
         mpc_q            <= '0;
         msign_q          <= 1'b0;
         mhigh_q          <= 1'b0;
         mrd_q            <= '0;
         out_valid_q      <= 1'b0;
         out_br_taken_q   <= 1'b0;
         out_misaligned_q <= 1'b0;
         out_alu_result_q <= '0;
         out_pc_next_q    <= '0;
         out_rd_q         <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (accept_s && is_mul_s) begin
                  mcand_q  <= {{XLEN{1'b0}}, a_mag_s};
                  mplier_q <= b_mag_s;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  msign_q  <= a_neg_s ^ b_neg_s;
                  mhigh_q  <= (alucode != ALU_MUL);
                  mpc_q    <= pc;
                  mrd_q    <= rd;
                  state_q  <= S_MUL_BUSY;
               end else if (accept_s) begin
                  out_valid_q      <= 1'b1;
                  out_alu_result_q <= alu_result_s;
                  out_pc_next_q    <= pc_next_d;
                  out_br_taken_q   <= alu_taken_s;
                  out_misaligned_q <= misaligned_d;
                  out_rd_q         <= rd;
               end
            end
            S_MUL_BUSY: begin
               if (mul_last_s && slot_free_s) begin
                  out_valid_q      <= 1'b1;
                  out_alu_result_q <= mul_result_d;
                  out_pc_next_q    <= mpc_q + XLEN'(32'd4);
                  out_br_taken_q   <= 1'b0;
                  out_misaligned_q <= 1'b0;
                  out_rd_q         <= mrd_q;
                  cnt_q            <= '0;
                  state_q          <= S_IDLE;
               end else if (cnt_q < CW'(XLEN)) begin
                  acc_q    <= acc_step_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  cnt_q    <= cnt_q + CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_valid      = out_valid_q;
   assign out_alu_result = out_alu_result_q;
   assign out_pc_next    = out_pc_next_q;
   assign out_br_taken   = out_br_taken_q;
   assign out_misaligned = out_misaligned_q;
   assign out_rd         = out_rd_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: alu ops, branches, multiplies, backpressure, flush, reset.
module tb_execute_stage;
   import execute_stage_pkg::*;

   logic        clk, rst, flush, in_valid, in_ready, out_ready;
   logic [31:0] pc, rs1, rs2, imm;
   logic [5:0]  alucode;
   logic [1:0]  aluop1_type, aluop2_type;
   logic [4:0]  rd;
   logic        out_valid, out_br_taken, out_misaligned;
   logic [31:0] out_alu_result, out_pc_next;
   logic [4:0]  out_rd;

   int errors = 0;
   int checks = 0;

   execute_stage #(.XLEN(32), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .pc(pc), .alucode(alucode), .aluop1_type(aluop1_type), .aluop2_type(aluop2_type),
      .rs1(rs1), .rs2(rs2), .imm(imm), .rd(rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_alu_result(out_alu_result),
      .out_pc_next(out_pc_next), .out_br_taken(out_br_taken),
      .out_misaligned(out_misaligned), .out_rd(out_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] code, input logic [1:0] t1, input logic [1:0] t2,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [4:0] r);
      alucode = code; aluop1_type = t1; aluop2_type = t2;
      pc = p; rs1 = a; rs2 = b; imm = im; rd = r; in_valid = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      pc = '0; rs1 = '0; rs2 = '0; imm = '0; rd = '0;
      alucode = ALU_ADD; aluop1_type = OP_TYPE_REG; aluop2_type = OP_TYPE_REG;
      tick(); tick();
      rst = 1'b0; #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (out_alu_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", out_alu_result); end
      checks++; if (out_pc_next !== 32'h0) begin errors++; $display("FAIL reset_pc_next got %h exp 0", out_pc_next); end
      checks++; if ({out_br_taken, out_misaligned} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {out_br_taken, out_misaligned}); end
      checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", out_rd); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      drive(ALU_ADD, OP_TYPE_REG, OP_TYPE_REG, 32'h40, 32'd5, 32'd7, 32'h0, 5'd3);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
      checks++; if (out_alu_result !== 32'd12) begin errors++; $display("FAIL add_result got %h exp 0000000c", out_alu_result); end
      checks++; if (out_pc_next !== 32'h44) begin errors++; $display("FAIL add_pc_next got %h exp 00000044", out_pc_next); end
      checks++; if (out_rd !== 5'd3) begin errors++; $display("FAIL add_rd got %0d exp 3", out_rd); end
      checks++; if (out_br_taken !== 1'b0) begin errors++; $display("FAIL add_taken got %b exp 0", out_br_taken); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_branch();
      out_ready = 1'b1;
      drive(ALU_JALR, OP_TYPE_PC, OP_TYPE_IMM, 32'h100, 32'h2001, 32'h0, 32'h4, 5'd1);
      tick();
      checks++; if (out_pc_next !== 32'h2004) begin errors++; $display("FAIL jalr4_pc_next got %h exp 00002004", out_pc_next); end
      checks++; if ({out_br_taken, out_misaligned} !== 2'b10) begin errors++; $display("FAIL jalr4_flags got %b exp 10", {out_br_taken, out_misaligned}); end
      checks++; if (out_alu_result !== 32'h104) begin errors++; $display("FAIL jalr4_link got %h exp 00000104", out_alu_result); end
      drive(ALU_JALR, OP_TYPE_PC, OP_TYPE_IMM, 32'h100, 32'h2001, 32'h0, 32'h6, 5'd1);
      tick();
      checks++; if (out_pc_next !== 32'h2006) begin errors++; $display("FAIL jalr6_pc_next got %h exp 00002006", out_pc_next); end
      checks++; if ({out_br_taken, out_misaligned} !== 2'b11) begin errors++; $display("FAIL jalr6_flags got %b exp 11", {out_br_taken, out_misaligned}); end
      drive(ALU_BNE, OP_TYPE_REG, OP_TYPE_REG, 32'h200, 32'd1, 32'd2, 32'h10, 5'd0);
      tick();
      checks++; if ({out_br_taken, out_pc_next} !== {1'b1, 32'h210}) begin errors++; $display("FAIL bne_taken got %b/%h exp 1/00000210", out_br_taken, out_pc_next); end
      drive(ALU_BEQ, OP_TYPE_REG, OP_TYPE_REG, 32'h200, 32'd1, 32'd2, 32'h10, 5'd0);
      tick();
      in_valid = 1'b0;
      checks++; if ({out_br_taken, out_pc_next} !== {1'b0, 32'h204}) begin errors++; $display("FAIL beq_not_taken got %b/%h exp 0/00000204", out_br_taken, out_pc_next); end
      tick();
   endtask

   task automatic test_mul(input string name, input logic [5:0] code,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      out_ready = 1'b1;
      drive(code, OP_TYPE_REG, OP_TYPE_REG, 32'h300, a, b, 32'h0, 5'd9);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 31; i++) begin
         checks++;
         if ({out_valid, in_ready} !== 2'b00) begin
            errors++; $display("FAIL %s_busy cycle %0d valid/ready got %b exp 00", name, i + 1, {out_valid, in_ready});
         end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early got %b exp 0", name, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_done got %b exp 1", name, out_valid); end
      checks++; if (out_alu_result !== exp) begin errors++; $display("FAIL %s_result got %h exp %h", name, out_alu_result, exp); end
      checks++; if ({out_br_taken, out_pc_next, out_rd} !== {1'b0, 32'h304, 5'd9}) begin errors++; $display("FAIL %s_meta got %b/%h/%0d exp 0/00000304/9", name, out_br_taken, out_pc_next, out_rd); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [5:0]  codes [6] = '{ALU_SUB, ALU_XOR, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_SLL};
      logic [31:0] as    [6] = '{32'd5, 32'h0000F0F0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
      logic [31:0] bs    [6] = '{32'd7, 32'h0000FF00, 32'd4, 32'd1, 32'd1, 32'd31};
      logic [31:0] exps  [6] = '{32'hFFFFFFFE, 32'h00000FF0, 32'hF8000000, 32'd1, 32'd0, 32'h80000000};
      out_ready = 1'b1;
      drive(codes[0], OP_TYPE_REG, OP_TYPE_REG, 32'h0, as[0], bs[0], 32'h0, 5'd1);
      tick();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({out_valid, out_alu_result, out_rd} !== {1'b1, exps[i], 5'(i + 1)}) begin
            errors++; $display("FAIL b2b_%0d got %b/%h/%0d exp 1/%h/%0d", i, out_valid, out_alu_result, out_rd, exps[i], i + 1);
         end
         if (i < 5) drive(codes[i+1], OP_TYPE_REG, OP_TYPE_REG, 32'h0, as[i+1], bs[i+1], 32'h0, 5'(i + 2));
         else in_valid = 1'b0;
         tick();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(ALU_ADD, OP_TYPE_REG, OP_TYPE_REG, 32'h500, 32'd1, 32'd2, 32'h0, 5'd1);
      tick();
      drive(ALU_ADD, OP_TYPE_REG, OP_TYPE_REG, 32'h504, 32'd10, 32'd20, 32'h0, 5'd2);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({in_ready, out_valid, out_alu_result, out_pc_next, out_rd} !== {1'b0, 1'b1, 32'd3, 32'h504, 5'd1}) begin
            errors++; $display("FAIL bp_hold_%0d got %b/%b/%h/%h/%0d exp 0/1/00000003/00000504/1", i, in_ready, out_valid, out_alu_result, out_pc_next, out_rd);
         end
         tick();
      end
      out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, out_alu_result, out_rd} !== {1'b1, 32'd30, 5'd2}) begin
         errors++; $display("FAIL bp_no_bubble got %b/%h/%0d exp 1/0000001e/2", out_valid, out_alu_result, out_rd);
      end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_flush();
      int seen = 0;
      out_ready = 1'b1;
      drive(ALU_MUL, OP_TYPE_REG, OP_TYPE_REG, 32'h600, 32'd3, 32'd4, 32'h0, 5'd7);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      flush = 1'b1;
      drive(ALU_ADD, OP_TYPE_REG, OP_TYPE_REG, 32'h700, 32'd8, 32'd9, 32'h0, 5'd4);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
      tick();
      flush = 1'b0; #1;
      checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_idle got %b exp 01", {out_valid, in_ready}); end
      tick();
      in_valid = 1'b0;
      checks++; if ({out_valid, out_alu_result, out_rd} !== {1'b1, 32'd17, 5'd4}) begin errors++; $display("FAIL flush_next_add got %b/%h/%0d exp 1/00000011/4", out_valid, out_alu_result, out_rd); end
      tick();
      for (int i = 0; i < 35; i++) begin
         if (out_valid !== 1'b0) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_late_mul got %0d valid cycles exp 0", seen); end
   endtask

   task automatic test_rst_busy();
      out_ready = 1'b1;
      drive(ALU_MULHU, OP_TYPE_REG, OP_TYPE_REG, 32'h800, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'd5);
      tick();
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1; flush = 1'b1;
      drive(ALU_ADD, OP_TYPE_REG, OP_TYPE_REG, 32'h900, 32'd1, 32'd1, 32'h0, 5'd6);
      tick();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; #1;
      checks++;
      if ({out_valid, out_br_taken, out_misaligned, out_alu_result, out_pc_next, out_rd} !== 72'h0) begin
         errors++; $display("FAIL rst_busy_outputs got %b%b%b/%h/%h/%0d exp all zero", out_valid, out_br_taken, out_misaligned, out_alu_result, out_pc_next, out_rd);
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_busy_in_ready got %b exp 1", in_ready); end
      for (int i = 0; i < 34; i++) tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_no_late_mul got %b exp 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_branch();
      test_mul("mulh",    ALU_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
      test_mul("mulhu",   ALU_MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001);
      test_mul("mul",     ALU_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE);
      test_mul("mulh_min", ALU_MULH,  32'h80000000, 32'h80000000, 32'h40000000);
      test_mul("mulhsu",  ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      test_mul("mulh_zero", ALU_MULH, 32'hFFFFFFFB, 32'h00000000, 32'h00000000);
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_rst_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Next-generation RV32 execute stage, parametrised in data width (XLEN).
- Adds a valid/ready handshake on input and output, a registered result slot with backpressure, and pipeline flush.
- Adds an iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU) alongside the existing single-cycle alu.
- Sits between decode/register-read and memory/writeback; resolves branches and jump targets.

Parameters:
- XLEN, 32, datapath width of pc, operands, imm, results.
- ALIGN_CHECK, 1, 1 = flag taken branch/jump targets with target[1]=1 as misaligned; 0 = never flag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous kill of the in-flight op and the output slot
- in_valid  in  1  upstream presents an op
- in_ready  out  1  stage accepts the op this cycle
- pc  in  XLEN  pc of the op
- alucode  in  6  ALU_* code from define.vh; ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU are added to define.vh
- aluop1_type  in  2  OP_TYPE_REG/IMM/PC selector for op1
- aluop2_type  in  2  selector for op2
- rs1, rs2, imm  in  XLEN  operand sources
- rd  in  5  destination tag, passed through
- out_valid  out  1  output slot holds a result
- out_ready  in  1  downstream consumes the result
- out_alu_result  out  XLEN  result
- out_pc_next  out  XLEN  next pc
- out_br_taken  out  1  branch/jump taken
- out_misaligned  out  1  taken target misaligned
- out_rd  out  5  tag of the result

Behaviour:
- Operand mux is purely combinational, with no latches.
  - REG selects rs1 or rs2; IMM selects imm; PC selects pc.
  - Any other encoding drives 0.
- Reset (rst=1 at a clk edge):
  - out_valid, out_br_taken and out_misaligned go to 0.
  - All data outputs go to 0.
  - FSM goes to IDLE and the multiply counter goes to 0.
  - rst overrides flush and acceptance.
- FSM states:
  - IDLE: accepts ops.
  - MUL_BUSY: iterating.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready. No change of state or outputs occurs without an accept or a slot drain.
- Non-multiply op accepted at edge E:
  - Output slot loads at E (latency 1), out_valid=1.
  - out_alu_result comes from the alu module.
  - out_br_taken = alu br_taken.
- out_pc_next:
  - taken and alucode==ALU_JALR: (rs1+imm) with bit0 cleared.
  - taken, any other op: pc+imm.
  - not taken: pc+4.
  - All sums are mod 2^XLEN.
- out_misaligned = ALIGN_CHECK && taken && out_pc_next[1].
- Multiply op accepted at edge E:
  - Registers operand magnitudes, result sign and op kind; enters MUL_BUSY.
  - Signedness: MUL and MULH are signed×signed; MULHSU is signed rs1 × unsigned rs2; MULHU is unsigned×unsigned.
  - One shift-add step per cycle over the XLEN-bit multiplier, producing a 2*XLEN-bit magnitude product.
  - Product is negated if the sign flag is set.
- Multiply completion:
  - Result is written to the output slot at edge E+XLEN; out_valid=1 and state returns to IDLE.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
  - out_br_taken=0 and out_pc_next=pc+4.
  - in_ready=0 throughout MUL_BUSY.
- Backpressure:
  - While out_valid && !out_ready, all out_* signals hold stable.
  - A slot drain (out_valid && out_ready) and a new accept in the same cycle are allowed: the slot reloads with no bubble.
  - A drain with no accept clears out_valid.
- Multiply completion while the slot is still occupied:
  - The FSM stays in MUL_BUSY holding the final product until the slot is free.
  - It then writes on the first edge where !out_valid || out_ready.
- Flush at edge E:
  - out_valid goes to 0 and any MUL_BUSY op is aborted to IDLE.
  - Since in_ready=0 during flush, no op is accepted at E.
  - Data outputs may keep stale values.
- Operand corner cases follow RISC-V semantics:
  - Most negative × most negative: MULH = 0x40000000 at XLEN=32.
  - Multiplication by 0 yields 0 with no sign artefact.

Test Plan:
- Reset, then ADD: rs1=5, rs2=7, REG/REG -> out_valid 1 cycle after accept, out_alu_result=12, out_pc_next=pc+4, out_rd echoed.
- JALR: pc=0x100, rs1=0x2001, imm=0x4 -> out_pc_next=0x2004, out_br_taken=1, out_misaligned=0. Repeat with imm=0x6 -> 0x2006, out_misaligned=1.
- MULH: rs1=0xFFFFFFFF (−1), rs2=0x00000002 -> result 0xFFFFFFFF exactly 32 edges after accept; in_ready=0 throughout. MULHU on the same operands -> 0x00000001; MUL -> 0xFFFFFFFE.
- Backpressure: hold out_ready=0 for 3 cycles with a queued ADD -> outputs stable, in_ready=0. Raise out_ready with a new op valid -> drain and accept on the same edge, with no bubble.
- Flush 10 cycles into a MUL -> out_valid stays 0, state returns to IDLE, next ADD completes 1 cycle after accept.
- rst asserted in MUL_BUSY with flush=1 and in_valid=1 -> all outputs 0, in_ready=1 the following cycle.
